// File: rtl/keypad_conditioner_if.sv
// Key bundle between the raw keypad sources and the conditioner.
// The conditioner takes the slave side; the key source / consumer takes the master side.
interface keypad_conditioner_if #(
    parameter int NKEYS = 24
);
    logic [NKEYS-1:0] key_raw;
    logic [NKEYS-1:0] key_out;
    logic             key_valid;
    logic [4:0]       key_code;
    logic             key_new;

    modport master (
        output key_raw,
        input  key_out,
        input  key_valid,
        input  key_code,
        input  key_new
    );

    modport slave (
        input  key_raw,
        output key_out,
        output key_valid,
        output key_code,
        output key_new
    );
endinterface

// File: rtl/keypad_conditioner.sv
// Synchronises, debounces and stretches raw keypad levels; accepts one key at a time,
// lowest index first, and holds it long enough for the monitor's display scan to see it.
module keypad_conditioner #(
    parameter int NKEYS      = 24,
    parameter int TICK_DIV   = 25000,
    parameter int DEB_TICKS  = 8,
    parameter int HOLD_TICKS = 50
) (
    input  logic clk25,
    input  logic reset,
    keypad_conditioner_if.slave kp
);

    localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CMAX = (DEB_TICKS > HOLD_TICKS) ? DEB_TICKS : HOLD_TICKS;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [PW-1:0]    PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0]    DEB_LAST = CW'(DEB_TICKS - 1);
    localparam logic [CW-1:0]    HOLD_MIN = CW'(HOLD_TICKS);
    localparam logic [NKEYS-1:0] ONE_KEY  = {{(NKEYS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        HOLD,
        RELEASE
    } state_t;

    state_t           state, state_n;
    logic [NKEYS-1:0] sync_q, ks;
    logic [PW-1:0]    pre_cnt;
    logic             tick;
    logic [4:0]       cand, cand_n, low_idx;
    logic [CW-1:0]    cnt, cnt_n;
    logic             cand_hit;
    logic [NKEYS-1:0] out_q, out_n;
    logic             valid_q, valid_n;
    logic [4:0]       code_q, code_n;
    logic             new_q, new_n;

    // Two-flop synchroniser; key_raw is asynchronous to clk25.
    always_ff @(posedge clk25) begin
        if (!reset) begin
            sync_q <= '0;
            ks     <= '0;
        end else begin
            sync_q <= kp.key_raw;
            ks     <= sync_q;
        end
    end

    always_ff @(posedge clk25) begin
        if (!reset || tick) pre_cnt <= '0;
        else                pre_cnt <= pre_cnt + 1'b1;
    end

    assign tick     = (pre_cnt == PRE_LAST);
    assign cand_hit = ks[cand];

    // Descending scan so the lowest set index is the one that sticks.
    always_comb begin
        low_idx = '0;
        for (int i = NKEYS - 1; i >= 0; i--) begin
            if (ks[i]) low_idx = 5'(i);
        end
    end

    always_ff @(posedge clk25) begin
        if (!reset) begin
            state   <= IDLE;
            cand    <= '0;
            cnt     <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            code_q  <= '0;
            new_q   <= 1'b0;
        end else begin
            state   <= state_n;
            cand    <= cand_n;
            cnt     <= cnt_n;
            out_q   <= out_n;
            valid_q <= valid_n;
            code_q  <= code_n;
            new_q   <= new_n;
        end
    end

    always_comb begin
        state_n = state;
        cand_n  = cand;
        cnt_n   = cnt;
        out_n   = out_q;
        valid_n = valid_q;
        code_n  = code_q;
        new_n   = 1'b0;
        case (state)
            IDLE: begin
                if (|ks) begin
                    cand_n  = low_idx;
                    cnt_n   = '0;
                    state_n = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                // A single low sample on the candidate aborts; bounce is never reported.
                if (!cand_hit) begin
                    state_n = IDLE;
                end else if (tick) begin
                    if (cnt == DEB_LAST) begin
                        state_n = HOLD;
                        out_n   = ONE_KEY << cand;
                        valid_n = 1'b1;
                        code_n  = cand;
                        new_n   = 1'b1;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (cnt >= HOLD_MIN && !cand_hit) begin
                    state_n = RELEASE;
                    out_n   = '0;
                    valid_n = 1'b0;
                    code_n  = '0;
                    cnt_n   = '0;
                end else if (tick && cnt < HOLD_MIN) begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RELEASE: begin
                if (cand_hit) begin
                    cnt_n = '0;
                end else if (tick) begin
                    if (cnt == DEB_LAST) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign kp.key_out   = out_q;
    assign kp.key_valid = valid_q;
    assign kp.key_code  = code_q;
    assign kp.key_new   = new_q;

endmodule
